// File: rtl/alu_bist.sv
// Built-in self-test sequencer for an external combinational ALU: replays a
// loadable vector table and counts mismatches. Optional macro ALU_BIST_STOP_ON_FAIL_EN.
module alu_bist #(
    parameter int DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_en_i,
    input  logic [3:0]  load_addr_i,
    input  logic [28:0] load_data_i,
    input  logic [4:0]  num_vec_i,
    input  logic        start_i,
    output logic [7:0]  alu_a_o,
    output logic [7:0]  alu_b_o,
    output logic [3:0]  alu_op_o,
    input  logic [7:0]  alu_out_i,
    input  logic        alu_zero_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [4:0]  fail_count_o,
    output logic [3:0]  fail_index_o,
    output logic [1:0]  state_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [4:0]  num_q, num_d;
    logic [4:0]  fc_q, fc_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  fi_q, fi_d;

    // Table has no reset: contents are only meaningful once loaded.
    logic [28:0] table_q [DEPTH];
    logic [28:0] entry;
    logic [4:0]  num_clamp;
    logic        mismatch;
    logic        last_vec;

    assign entry     = table_q[idx_q[AW-1:0]];
    assign num_clamp = (num_vec_i > 5'(DEPTH)) ? 5'(DEPTH) : num_vec_i;
    assign mismatch  = (alu_out_i != entry[8:1]) || (alu_zero_i != entry[0]);
    assign last_vec  = ({1'b0, idx_q} + 5'd1) >= num_q;

    always_ff @(posedge clk_i) begin
        if (state_q == S_IDLE && load_en_i) begin
            table_q[load_addr_i[AW-1:0]] <= load_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            op_q    <= 4'd0;
            num_q   <= 5'd0;
            fc_q    <= 5'd0;
            idx_q   <= 4'd0;
            fi_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            num_q   <= num_d;
            fc_q    <= fc_d;
            idx_q   <= idx_d;
            fi_q    <= fi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        num_d   = num_q;
        fc_d    = fc_q;
        idx_d   = idx_q;
        fi_d    = fi_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    num_d   = num_clamp;
                    fc_d    = 5'd0;
                    fi_d    = 4'd0;
                    idx_d   = 4'd0;
                    state_d = (num_clamp == 5'd0) ? S_DONE : S_DRIVE;
                end
            end
            S_DRIVE: begin
                op_d    = entry[28:25];
                a_d     = entry[24:17];
                b_d     = entry[16:9];
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    if (fc_q != 5'd31) fc_d = fc_q + 5'd1;
                    if (fc_q == 5'd0) fi_d = idx_q;
                end
`ifdef ALU_BIST_STOP_ON_FAIL_EN
                if (mismatch || last_vec) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_DRIVE;
                end
`else
                if (last_vec) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_DRIVE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign alu_op_o     = op_q;
    assign busy_o       = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign done_o       = (state_q == S_DONE);
    assign pass_o       = (state_q == S_DONE) && (fc_q == 5'd0);
    assign fail_count_o = fc_q;
    assign fail_index_o = fi_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist with a small behavioural ALU on the operand outputs.
module tb_alu_bist;

    localparam logic [3:0] K_ADD = 4'd0;
    localparam logic [3:0] K_SUB = 4'd1;
    localparam logic [3:0] K_AND = 4'd2;
    localparam logic [3:0] K_OR  = 4'd3;
    localparam logic [3:0] K_XOR = 4'd4;
    localparam logic [3:0] K_SEQ = 4'd5;
    localparam logic [3:0] K_SLT = 4'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = 4'd0;
    logic [28:0] load_data = 29'd0;
    logic [4:0]  num_vec = 5'd0;
    logic        start = 1'b0;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic        alu_zero;
    logic        busy, done, pass;
    logic [4:0]  fail_count;
    logic [3:0]  fail_index;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_bist #(.DEPTH(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data),
        .num_vec_i(num_vec), .start_i(start),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_out_i(alu_out), .alu_zero_i(alu_zero),
        .busy_o(busy), .done_o(done), .pass_o(pass),
        .fail_count_o(fail_count), .fail_index_o(fail_index), .state_o(state)
    );

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            K_ADD:   return a + b;
            K_SUB:   return a - b;
            K_AND:   return a & b;
            K_OR:    return a | b;
            K_XOR:   return a ^ b;
            K_SEQ:   return (a == b) ? 8'd1 : 8'd0;
            K_SLT:   return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    always_comb begin
        alu_out  = alu_f(alu_op, alu_a, alu_b);
        alu_zero = (alu_out == 8'd0);
    end

    function automatic logic [28:0] vec(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] e, input logic ez);
        return {op, a, b, e, ez};
    endfunction

    function automatic logic [28:0] good_vec(input int i);
        logic [3:0] op;
        logic [7:0] a, b, e;
        op = 4'(i % 7);
        a  = 8'(i * 13 + 5);
        b  = 8'(i * 7 + 3);
        e  = alu_f(op, a, b);
        return {op, a, b, e, (e == 8'd0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic load(input logic [3:0] addr, input logic [28:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Returns just after the edge that samples start.
    task automatic start_run(input logic [4:0] n);
        num_vec = n;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_a", 32'(alu_a), 32'd0);
        check("rst_fc", 32'(fail_count), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single passing ADD vector
        load(4'd0, vec(K_ADD, 8'd10, 8'd1, 8'd11, 1'b0));
        start_run(5'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_state_drive", 32'(state), 32'd1);
        cyc(1);
        check("t1_a", 32'(alu_a), 32'd10);
        check("t1_b", 32'(alu_b), 32'd1);
        check("t1_op", 32'(alu_op), 32'(K_ADD));
        check("t1_done_early", 32'(done), 32'd0);
        cyc(1);
        check("t1_done", 32'(done), 32'd1);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_fc", 32'(fail_count), 32'd0);
        check("t1_busy_off", 32'(busy), 32'd0);

        // Second of two vectors fails
        rst_pulse();
        load(4'd0, vec(K_XOR, 8'd10, 8'd10, 8'd0, 1'b1));
        load(4'd1, vec(K_AND, 8'd10, 8'd10, 8'd99, 1'b0));
        start_run(5'd2);
        cyc(3);
        check("t2_done_early", 32'(done), 32'd0);
        cyc(1);
        check("t2_done", 32'(done), 32'd1);
        check("t2_fc", 32'(fail_count), 32'd1);
        check("t2_fi", 32'(fail_index), 32'd1);
        check("t2_pass", 32'(pass), 32'd0);

        // Four wrong expectations
        rst_pulse();
        load(4'd0, vec(K_ADD, 8'd1, 8'd2, 8'd4, 1'b0));
        load(4'd1, vec(K_SUB, 8'd5, 8'd3, 8'd3, 1'b0));
        load(4'd2, vec(K_OR,  8'd1, 8'd2, 8'd0, 1'b1));
        load(4'd3, vec(K_SLT, 8'd1, 8'd2, 8'd0, 1'b1));
        start_run(5'd4);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
        cyc(1);
        check("t3_done_early", 32'(done), 32'd0);
        cyc(1);
        check("t3_done", 32'(done), 32'd1);
        check("t3_fc", 32'(fail_count), 32'd1);
`else
        cyc(7);
        check("t3_done_early", 32'(done), 32'd0);
        cyc(1);
        check("t3_done", 32'(done), 32'd1);
        check("t3_fc", 32'(fail_count), 32'd4);
`endif
        check("t3_fi", 32'(fail_index), 32'd0);
        check("t3_pass", 32'(pass), 32'd0);

        // Zero vectors
        rst_pulse();
        start_run(5'd0);
        check("t4_done", 32'(done), 32'd1);
        check("t4_pass", 32'(pass), 32'd1);
        check("t4_a", 32'(alu_a), 32'd0);
        check("t4_b", 32'(alu_b), 32'd0);
        check("t4_op", 32'(alu_op), 32'd0);

        // Reset in the middle of an 8-vector run
        rst_pulse();
        for (int i = 0; i < 8; i++) load(4'(i), good_vec(i));
        start_run(5'd8);
        cyc(5);
        check("t5_busy_mid", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_a", 32'(alu_a), 32'd0);
        check("t5_rst_b", 32'(alu_b), 32'd0);
        check("t5_rst_op", 32'(alu_op), 32'd0);
        check("t5_rst_state", 32'(state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Load and start in the same idle cycle
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = vec(K_AND, 8'hF0, 8'h3C, 8'h30, 1'b0);
        num_vec   = 5'd1;
        start     = 1'b1;
        @(negedge clk);
        load_en   = 1'b0;
        start     = 1'b0;
        cyc(1);
        check("t5_a", 32'(alu_a), 32'hF0);
        check("t5_op", 32'(alu_op), 32'(K_AND));
        cyc(1);
        check("t5_done", 32'(done), 32'd1);
        check("t5_pass", 32'(pass), 32'd1);

        // NumVec clamps to DEPTH; Start/LoadEn during the run are ignored
        rst_pulse();
        for (int i = 0; i < 16; i++) load(4'(i), good_vec(i));
        start_run(5'd20);
        cyc(3);
        start     = 1'b1;
        num_vec   = 5'd1;
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = vec(K_ADD, 8'hEE, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        start     = 1'b0;
        load_en   = 1'b0;
        cyc(27);
        check("t6_done_early", 32'(done), 32'd0);
        cyc(1);
        check("t6_done", 32'(done), 32'd1);
        check("t6_pass", 32'(pass), 32'd1);
        check("t6_fc", 32'(fail_count), 32'd0);
        check("t6_last_a", 32'(alu_a), 32'd200);
        check("t6_last_b", 32'(alu_b), 32'd108);
        check("t6_last_op", 32'(alu_op), 32'(K_SUB));
        cyc(3);
        check("t6_hold_done", 32'(done), 32'd1);
        check("t6_hold_a", 32'(alu_a), 32'd200);
        start_run(5'd1);
        cyc(1);
        check("t6_rerun_a", 32'(alu_a), 32'd5);
        cyc(1);
        check("t6_rerun_pass", 32'(pass), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
